// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, the centred 512x384 bitmap window and the pixel colour type.
package vga_pkg;

  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_FP_END   = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_TOTAL    = 10'd800;

  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_FP_END   = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_TOTAL    = 10'd525;

  localparam logic [9:0] WIN_H0 = 10'd64;
  localparam logic [9:0] WIN_V0 = 10'd48;
  localparam logic [9:0] WIN_W  = 10'd512;
  localparam logic [9:0] WIN_H  = 10'd384;

  localparam logic [9:0] BYTES_PER_LINE = 10'd32;
  // Screen pixels covered by one source byte: 8 bits, each doubled.
  localparam logic [9:0] GROUP_W = 10'd16;

  typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] h,
  output logic [9:0] v
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DivW-1:0] div_q;
  logic [9:0]      h_q;
  logic [9:0]      v_q;

  assign pix_tick = (div_q == DivW'(DIV - 1));
  assign h        = h_q;
  assign v        = v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else if (pix_tick) begin
      div_q <= '0;
      if (h_q == H_TOTAL - 10'd1) begin
        h_q <= '0;
        v_q <= (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

endmodule

// File: rtl/vga_fetch.sv
// Video-side framebuffer reader: 256x192 mono bitmap doubled into a bordered 640x480 raster.
module vga_fetch
  import vga_pkg::*;
#(
  parameter int unsigned ADDR         = 16,
  parameter int unsigned DIV          = 4,
  parameter rgb332_t     FG_COLOR     = 8'hFF,
  parameter rgb332_t     BG_COLOR     = 8'h00,
  parameter rgb332_t     BORDER_COLOR = 8'h02
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-1:0] fb_base,
  output logic            rd_en,
  output logic [ADDR-1:0] rd_addr,
  input  logic [7:0]      rd_data,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output rgb332_t         pix,
  output logic            vblank_irq
);

  logic       pix_tick;
  logic [9:0] h;
  logic [9:0] v;

  vga_timing #(
    .DIV(DIV)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick),
    .h        (h),
    .v        (v)
  );

  logic [ADDR-1:0] base_q;
  logic [7:0]      cur_byte_q;
  logic [7:0]      nxt_byte_q;
  logic            cap_q;

  logic [9:0] h_nx;
  logic       win_line, win_col, visible;
  logic       fetch_hit, load_hit, frame_end, vblank_hit;
  logic [4:0] g;
  logic [7:0] sy;
  rgb332_t    pix_d;

  assign h_nx     = h + 10'd1;
  assign win_line = (v >= WIN_V0) && (v < WIN_V0 + WIN_H);
  assign win_col  = (h >= WIN_H0) && (h < WIN_H0 + WIN_W);
  assign visible  = (h < H_VIS) && (v < V_VIS);

  // Each byte is fetched one group ahead of the screen position that shows it.
  assign fetch_hit = pix_tick && win_line && (h >= WIN_H0 - GROUP_W)
                     && (h < WIN_H0 - GROUP_W + BYTES_PER_LINE * GROUP_W) && (h[3:0] == 4'd0);
  // Load as the counter enters a group so the first pixel of the group already sees it.
  assign load_hit  = pix_tick && (h_nx >= WIN_H0) && (h_nx < WIN_H0 + WIN_W)
                     && (h_nx[3:0] == 4'd0);
  assign frame_end  = pix_tick && (h == H_TOTAL - 10'd1) && (v == V_TOTAL - 10'd1);
  assign vblank_hit = pix_tick && (h == H_TOTAL - 10'd1) && (v == V_VIS - 10'd1);

  assign g  = 5'((h - (WIN_H0 - GROUP_W)) >> 4);
  assign sy = 8'((v - WIN_V0) >> 1);

  always_comb begin
    pix_d = '0;
    if (visible) begin
      if (win_line && win_col) begin
        pix_d = cur_byte_q[~h[3:1]] ? FG_COLOR : BG_COLOR;
      end else begin
        pix_d = BORDER_COLOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      cur_byte_q <= '0;
      nxt_byte_q <= '0;
      cap_q      <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      pix        <= '0;
      vblank_irq <= 1'b0;
    end else begin
      rd_en <= fetch_hit;
      if (fetch_hit) begin
        rd_addr <= base_q + ADDR'({sy, g});
      end
      cap_q <= rd_en;
      if (cap_q) begin
        nxt_byte_q <= rd_data;
      end
      if (load_hit) begin
        cur_byte_q <= nxt_byte_q;
      end
      if (frame_end) begin
        base_q <= fb_base;
      end
      hsync      <= !((h >= H_FP_END) && (h < H_SYNC_END));
      vsync      <= !((v >= V_FP_END) && (v < V_SYNC_END));
      de         <= visible;
      pix        <= pix_d;
      vblank_irq <= vblank_hit;
    end
  end

endmodule
